conv_window_buffer: RTL and testbench
=====================================

// Module: conv_window_buffer
// PURPOSE
//   Streaming KxK sliding-window generator for the LeNet5 conv layers. Accepts one
//   raster-order pixel per handshake, stores K-1 previous rows in circular line
//   memories and presents a full KxK window with its top-left coordinate.
//   Sits between the feature-map source and the conv MAC array.
// PARAMETERS
//   COLS       32  pixels per row (>= K)
//   ROWS       32  rows per frame (>= K)
//   K           5  kernel size (>= 2)
//   BIT_WIDTH   8  bits per pixel
// PORTS
//   clk        in   1                clock, rising edge
//   rst        in   1                asynchronous, active-high reset
//   clear      in   1                synchronous frame restart
//   in_valid   in   1                in_pixel valid
//   in_ready   out  1                block can accept a pixel
//   in_pixel   in   BIT_WIDTH        raster-order pixel
//   win_valid  out  1                win_* hold a valid window
//   win_ready  in   1                consumer takes window
//   win_data   out  K*K*BIT_WIDTH    window; element (r,c) at [(r*K+c)*BIT_WIDTH +: BIT_WIDTH]
//   win_row    out  $clog2(ROWS)     top-left row of window
//   win_col    out  $clog2(COLS)     top-left col of window
//   frame_done out  1                1-cycle pulse: last pixel of frame accepted
// BEHAVIOUR
//   - Reset: in_ready=1, win_valid=0, win_data=0, win_row=0, win_col=0, frame_done=0,
//     col_cnt=row_cnt=0. Line memories are not reset.
//   - in_ready = ~win_valid | win_ready (combinational). Accept = in_valid & in_ready.
//   - On accept with pixel at (row_cnt,col_cnt): read column col_cnt of all K-1 line
//     memories, then write the new pixel into that column of the newest line (chain
//     shifts: line j gets the old line j+1 value). Window regs shift left by one column;
//     the new rightmost column = {K-1 line values, in_pixel}, row 0 = oldest (top).
//   - Latency 1: window completed by a pixel accepted at edge t is valid after edge t.
//   - win_valid set on accept when row_cnt >= K-1 and col_cnt >= K-1; win_row =
//     row_cnt-(K-1), win_col = col_cnt-(K-1). Otherwise, on accept or win_ready,
//     win_valid clears. Held stable while win_valid & ~win_ready.
//   - Counters: col_cnt wraps COLS-1 -> 0 with row_cnt+1; at (ROWS-1,COLS-1) both wrap
//     to 0 and frame_done pulses the next cycle. Windows never straddle a row wrap
//     (col gating), so shift-register contents from the previous row are harmless.
//   - Stale line data from a previous frame is never exposed: first K-1 rows gated.
//   - clear: next edge zeroes counters, win_valid and frame_done; clear wins over a
//     simultaneous accept (pixel dropped, in_ready still reported).
//   - rst mid-frame: immediate return to reset state; frame restarts at (0,0).
//   - Windows per frame: (ROWS-K+1)*(COLS-K+1).
// STRUCTURE
//   - Shared package cnn_pkg: clog2 helper, pixel_t width constant, window packing
//     index function win_idx(r,c).
//   - Sub-module line_ram (#(COLS, BIT_WIDTH)): single-port depth-COLS memory, read
//     old value / write new value at same address in one cycle; K-1 instances chained.
//   - Top holds counters, window register array, handshake and coordinate logic.
// TESTING
//   1 Defaults, pixel=(row*32+col)%256, win_ready=1 -> first win_valid after (4,4)
//     accepted; win_row=win_col=0, element(0,0)=0, element(4,4)=132.
//   2 Full frame, win_ready=1 -> exactly 784 windows, coords scan 0..27 raster order,
//     no window with win_col>27; frame_done once after pixel (31,31).
//   3 win_ready=0 for 5 cycles while win_valid -> in_ready=0, win_* stable; no pixel lost,
//     next window element(4,4) = next pixel value.
//   4 Random in_valid gaps (50%) -> window sequence identical to scenario 2.
//   5 rst asserted at (10,7) then new frame -> first window again after (4,4), values
//     from new frame only; clear at (20,3) with in_valid=1 -> pixel dropped, same result.
//   6 Two back-to-back frames -> 2x784 windows, 2 frame_done pulses, frame 2 windows
//     contain no frame 1 pixels.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming blocks: pixel type, width helper,
// and the flat index of a window element.
package cnn_pkg;

  localparam int unsigned PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Bits needed to address v entries; never less than one.
  function automatic int unsigned clog2w(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

  // Row-major element number of (r,c) in a k x k window.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One row of pixel history: combinational read of the old value and write of the
// new value at the same address on a single clock edge.
module line_ram
  import cnn_pkg::*;
#(
  parameter int unsigned COLS      = 32,
  parameter int unsigned BIT_WIDTH = PIXEL_W,
  localparam int unsigned AW       = clog2w(COLS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [BIT_WIDTH-1:0] wdata,
  output logic [BIT_WIDTH-1:0] rdata
);

  logic [BIT_WIDTH-1:0] mem [COLS];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming KxK sliding-window generator: K-1 chained line memories feed the
// rightmost column of a window register that shifts left on every accepted pixel.
module conv_window_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned COLS      = 32,
  parameter int unsigned ROWS      = 32,
  parameter int unsigned K         = 5,
  parameter int unsigned BIT_WIDTH = PIXEL_W,
  localparam int unsigned CW       = clog2w(COLS),
  localparam int unsigned RW       = clog2w(ROWS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIT_WIDTH-1:0]     in_pixel,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [K*K*BIT_WIDTH-1:0] win_data,
  output logic [RW-1:0]            win_row,
  output logic [CW-1:0]            win_col,
  output logic                     frame_done
);

  logic [CW-1:0]        col_cnt;
  logic [RW-1:0]        row_cnt;
  logic                 accept, take;
  logic                 row_ok, col_ok, last_col, last_row;
  logic [BIT_WIDTH-1:0] line_rd [K-1];
  logic [BIT_WIDTH-1:0] line_wr [K-1];
  logic [BIT_WIDTH-1:0] new_col [K];
  logic [BIT_WIDTH-1:0] win_q   [K][K];

  assign in_ready = ~win_valid | win_ready;
  assign accept   = in_valid & in_ready;
  // clear drops a simultaneous pixel entirely
  assign take     = accept & ~clear;

  assign row_ok   = row_cnt >= RW'(K - 1);
  assign col_ok   = col_cnt >= CW'(K - 1);
  assign last_col = col_cnt == CW'(COLS - 1);
  assign last_row = row_cnt == RW'(ROWS - 1);

  // Line 0 holds the oldest row; each line inherits the value of the line below it.
  for (genvar j = 0; j < K - 1; j++) begin : g_line
    if (j == K - 2) begin : g_newest
      assign line_wr[j] = in_pixel;
    end else begin : g_chain
      assign line_wr[j] = line_rd[j+1];
    end
    line_ram #(
      .COLS      (COLS),
      .BIT_WIDTH (BIT_WIDTH)
    ) u_line (
      .clk   (clk),
      .we    (take),
      .addr  (col_cnt),
      .wdata (line_wr[j]),
      .rdata (line_rd[j])
    );
  end

  always_comb begin
    for (int r = 0; r < K - 1; r++) new_col[r] = line_rd[r];
    new_col[K-1] = in_pixel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= last_row ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
    end else if (take) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= take & last_col & last_row;
      if (clear) begin
        win_valid <= 1'b0;
      end else if (accept) begin
        win_valid <= row_ok & col_ok;
        if (row_ok & col_ok) begin
          win_row <= row_cnt - RW'(K - 1);
          win_col <= col_cnt - CW'(K - 1);
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_data[win_idx(r, c, K)*BIT_WIDTH +: BIT_WIDTH] = win_q[r][c];
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench: a frame-image model predicts every window; a monitor pops and
// compares each window the DUT hands over.
module tb_conv_window_buffer;

  localparam int COLS = 32;
  localparam int ROWS = 32;
  localparam int K    = 5;
  localparam int BW   = 8;
  localparam int DW   = K * K * BW;
  localparam int WPF  = (ROWS - K + 1) * (COLS - K + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_pixel = '0;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic [DW-1:0] win_data;
  logic [4:0]    win_row;
  logic [4:0]    win_col;
  logic          frame_done;

  conv_window_buffer #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .K         (K),
    .BIT_WIDTH (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            row;
    int            col;
  } win_t;

  win_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            mr = 0;
  int            mc = 0;
  logic [BW-1:0] img [ROWS][COLS];
  bit            fd_due = 0;
  int            fd_seen = 0;
  int            win_seen = 0;
  int            rdy_mode = 0;
  win_t          first_win;
  bit            got_first = 0;
  win_t          exp_w;
  win_t          got_w;
  bit            hold = 0;
  win_t          held;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: remembers the frame as an image and cuts windows out of it.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      sb.delete();
      mr = 0;
      mc = 0;
      fd_due = 0;
    end else begin
      chk("frame_done", frame_done, fd_due);
      chk("in_ready", in_ready, !win_valid || win_ready);
      fd_due = 0;
      if (clear) begin
        sb.delete();
        mr = 0;
        mc = 0;
      end else if (in_valid && in_ready) begin
        img[mr][mc] = in_pixel;
        if (mr >= K - 1 && mc >= K - 1) begin
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              exp_w.data[(r*K+c)*BW +: BW] = img[mr-K+1+r][mc-K+1+c];
          exp_w.row = mr - K + 1;
          exp_w.col = mc - K + 1;
          sb.push_back(exp_w);
        end
        if (mc == COLS - 1) begin
          mc = 0;
          if (mr == ROWS - 1) begin
            mr = 0;
            fd_due = 1;
          end else begin
            mr++;
          end
        end else begin
          mc++;
        end
      end
    end
  end

  // Monitor: checks every window handed over and stability while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_seen++;
      if (hold) begin
        chk("stall_valid", win_valid, 1);
        chk("stall_row", win_row, held.row);
        chk("stall_col", win_col, held.col);
        chk("stall_data", win_data == held.data, 1);
      end
      if (win_valid && win_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_window", 1, 0);
        end else begin
          exp_w = sb.pop_front();
          chk("win_row", win_row, exp_w.row);
          chk("win_col", win_col, exp_w.col);
          n_cmp++;
          if (win_data !== exp_w.data) begin
            n_bad++;
            $display("FAIL win_data at (%0d,%0d): got %h expected %h",
                     exp_w.row, exp_w.col, win_data, exp_w.data);
          end
          win_seen++;
          if (!got_first) begin
            got_first = 1;
            first_win.data = win_data;
            first_win.row  = win_row;
            first_win.col  = win_col;
          end
        end
      end
    end
    hold = !rst && !clear && win_valid && !win_ready;
    held.data = win_data;
    held.row  = win_row;
    held.col  = win_col;
  end

  // Consumer: always ready, or random back-pressure with occasional 5-cycle stalls.
  initial begin
    int stall;
    stall = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        win_ready = 1'b1;
      end else if (stall > 0) begin
        win_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 29) == 0) begin
        win_ready = 1'b0;
        stall = 4;
      end else begin
        win_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send(input logic [BW-1:0] p, input bit gaps);
    bit acc;
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_pixel = p;
    guard = 0;
    acc = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic run_pixels(input int n, input bit pattern, input bit gaps);
    for (int i = 0; i < n; i++)
      send(pattern ? BW'((mr * 32 + mc) % 256) : BW'($urandom), gaps);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base_w;
    int base_f;
    logic [BW-1:0] v;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_win_data_zero", win_data == '0, 1);
    @(posedge clk);
    #1;

    // Ramp frame, always ready
    run_pixels(COLS * ROWS, 1, 0);
    idle(4);
    chk("frame1_windows", win_seen, WPF);
    chk("frame1_done", fd_seen, 1);
    chk("first_row", first_win.row, 0);
    chk("first_col", first_win.col, 0);
    v = first_win.data[0 +: BW];
    chk("first_e00", v, 0);
    v = first_win.data[(4*K+4)*BW +: BW];
    chk("first_e44", v, 132);

    // Random pixels, input gaps and back-pressure
    rdy_mode = 1;
    run_pixels(COLS * ROWS, 0, 1);
    rdy_mode = 0;
    idle(10);
    chk("frame2_windows", win_seen, 2 * WPF);
    chk("frame2_done", fd_seen, 2);

    // Reset in the middle of a frame
    while (!(mr == 10 && mc == 7)) send(BW'($urandom), 0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_mid_valid", win_valid, 0);
    base_w = win_seen;
    base_f = fd_seen;
    run_pixels(COLS * ROWS, 0, 0);
    idle(4);
    chk("after_rst_windows", win_seen - base_w, WPF);
    chk("after_rst_done", fd_seen - base_f, 1);

    // Clear with a simultaneous pixel
    while (!(mr == 20 && mc == 3)) send(BW'($urandom), 0);
    in_valid = 1'b1;
    in_pixel = BW'($urandom);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    in_valid = 1'b0;
    base_w = win_seen;
    base_f = fd_seen;
    run_pixels(COLS * ROWS, 0, 0);
    idle(4);
    chk("after_clear_windows", win_seen - base_w, WPF);
    chk("after_clear_done", fd_seen - base_f, 1);

    // Two back-to-back frames
    base_w = win_seen;
    base_f = fd_seen;
    run_pixels(2 * COLS * ROWS, 0, 0);
    idle(4);
    chk("b2b_windows", win_seen - base_w, 2 * WPF);
    chk("b2b_done", fd_seen - base_f, 2);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
